ptp_trig_gen: RTL and testbench

- Consumes the RTC PTP time (48-bit seconds, 32-bit nanoseconds) in the rtc clock domain.
- Generates a programmable pulse train that is aligned to absolute PTP target times.
- Timestamps rising edges of an external event input into a small FIFO for the host.
- Sits directly downstream of the RTC time outputs, beside the one-PPS output.

---
 rtl/ptp_trig_pkg.sv | 47 ++++
 rtl/ptp_ts_fifo.sv | 60 ++++++
 rtl/ptp_trig_gen.sv | 154 +++++++++++++++
 tb/tb_ptp_trig_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_trig_pkg.sv
// Shared PTP time type, trigger FSM states and time arithmetic helpers.
// Time is {sec[47:0], ns[31:0]}; ns is always below the wrap value.
package ptp_trig_pkg;

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    typedef struct packed {
        logic [47:0] sec;
        logic [31:0] ns;
    } ptp_time_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } trig_state_t;

    // a + delta ns; delta <= wrap so at most one carry into seconds
    function automatic ptp_time_t time_add(
        input ptp_time_t   a,
        input logic [31:0] delta,
        input logic [31:0] wrap
    );
        logic [32:0] sum;
        logic [32:0] dif;
        ptp_time_t   r;
        sum = {1'b0, a.ns} + {1'b0, delta};
        dif = sum - {1'b0, wrap};
        r   = a;
        if (sum >= {1'b0, wrap}) begin
            r.ns  = dif[31:0];
            r.sec = a.sec + 48'd1;
        end else begin
            r.ns  = sum[31:0];
        end
        return r;
    endfunction

    // unsigned 80-bit a >= b
    function automatic logic time_ge(
        input ptp_time_t a,
        input ptp_time_t b
    );
        return {a.sec, a.ns} >= {b.sec, b.ns};
    endfunction

endpackage

// File: rtl/ptp_ts_fifo.sv
// First-word-fall-through timestamp FIFO with sticky overflow flag.
// Ports: wr_en/wr_data push, rd_en pops head rd_data; full, empty, ovf(+ovf_clr).
module ptp_ts_fifo
    import ptp_trig_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  ptp_time_t wr_data,
    input  logic      rd_en,
    output ptp_time_t rd_data,
    output logic      full,
    output logic      empty,
    output logic      ovf,
    input  logic      ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    ptp_time_t   mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_rd;
    logic        do_wr;
    logic        drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // a pop frees the slot the write lands in, so both go through when full
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && full && !do_rd;

    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            // a new drop wins over a clear in the same cycle
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/ptp_trig_gen.sv
// PTP-aligned programmable pulse train plus event timestamp capture.
// Ports: time_ptp_*, cfg_*/arm/disarm in; trig_* status out; evt_* FIFO side.
module ptp_trig_gen #(
    parameter logic [31:0] NS_PER_SEC = ptp_trig_pkg::NS_PER_SEC,
    parameter int          EVT_DEPTH  = 4,
    parameter int          CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [47:0]       time_ptp_sec,
    input  logic [31:0]       time_ptp_ns,
    input  logic              cfg_ld,
    input  logic [47:0]       cfg_target_sec,
    input  logic [31:0]       cfg_target_ns,
    input  logic [31:0]       cfg_period_ns,
    input  logic [31:0]       cfg_width_ns,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              arm,
    input  logic              disarm,
    output logic              trig_out,
    output logic              trig_busy,
    output logic              trig_done,
    output logic              trig_late,
    output logic              cfg_err,
    input  logic              evt_in,
    input  logic              evt_rd_en,
    output logic [79:0]       evt_ts_out,
    output logic              evt_empty,
    output logic              evt_ovf,
    input  logic              evt_ovf_clr
);

    import ptp_trig_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    trig_state_t      state;
    ptp_time_t        now;
    ptp_time_t        tgt_q;
    ptp_time_t        rise_t;
    ptp_time_t        fall_t;
    logic [31:0]      period_q;
    logic [31:0]      width_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] remaining;
    logic             cfg_ok;
    logic             evt_prev;
    logic             evt_edge;
    logic             evt_full;
    ptp_time_t        evt_head;

    assign now.sec = time_ptp_sec;
    assign now.ns  = time_ptp_ns;

    assign cfg_ok = (period_q != 32'd0) && (period_q <= NS_PER_SEC) &&
                    (width_q != 32'd0) && (width_q < period_q);

    assign trig_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tgt_q     <= '0;
            rise_t    <= '0;
            fall_t    <= '0;
            period_q  <= '0;
            width_q   <= '0;
            count_q   <= '0;
            remaining <= '0;
            trig_out  <= 1'b0;
            trig_done <= 1'b0;
            trig_late <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            trig_done <= 1'b0;
            if (cfg_ld && state == IDLE) begin
                tgt_q    <= '{sec: cfg_target_sec, ns: cfg_target_ns};
                period_q <= cfg_period_ns;
                width_q  <= cfg_width_ns;
                count_q  <= cfg_count;
            end
            if (disarm) begin
                state    <= IDLE;
                trig_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm && !cfg_ok) begin
                            cfg_err <= 1'b1;
                        end else if (arm) begin
                            rise_t    <= tgt_q;
                            remaining <= count_q;
                            cfg_err   <= 1'b0;
                            trig_late <= time_ge(now, tgt_q);
                            state     <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (time_ge(now, rise_t)) begin
                            trig_out <= 1'b1;
                            fall_t   <= time_add(rise_t, width_q, NS_PER_SEC);
                            rise_t   <= time_add(rise_t, period_q, NS_PER_SEC);
                            state    <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (time_ge(now, fall_t)) begin
                            trig_out <= 1'b0;
                            // count 0 runs forever: remaining never moves
                            if (count_q != '0) begin
                                remaining <= remaining - CNT_ONE;
                            end
                            if (count_q != '0 && remaining == CNT_ONE) begin
                                trig_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state     <= WAIT_RISE;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        trig_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) evt_prev <= 1'b0;
        else      evt_prev <= evt_in;
    end

    assign evt_edge = evt_in && !evt_prev;

    ptp_ts_fifo #(
        .DEPTH(EVT_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (evt_edge),
        .wr_data(now),
        .rd_en  (evt_rd_en),
        .rd_data(evt_head),
        .full   (evt_full),
        .empty  (evt_empty),
        .ovf    (evt_ovf),
        .ovf_clr(evt_ovf_clr)
    );

    assign evt_ts_out = {evt_head.sec, evt_head.ns};

endmodule

// File: tb/tb_ptp_trig_gen.sv
// Directed self-checking bench for ptp_trig_gen.
// Drives PTP time by hand and checks pulses, flags and event FIFO.
module tb_ptp_trig_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] time_ptp_sec;
    logic [31:0] time_ptp_ns;
    logic        cfg_ld;
    logic [47:0] cfg_target_sec;
    logic [31:0] cfg_target_ns;
    logic [31:0] cfg_period_ns;
    logic [31:0] cfg_width_ns;
    logic [15:0] cfg_count;
    logic        arm;
    logic        disarm;
    logic        trig_out;
    logic        trig_busy;
    logic        trig_done;
    logic        trig_late;
    logic        cfg_err;
    logic        evt_in;
    logic        evt_rd_en;
    logic [79:0] evt_ts_out;
    logic        evt_empty;
    logic        evt_ovf;
    logic        evt_ovf_clr;

    int n_run  = 0;
    int n_fail = 0;

    ptp_trig_gen #(
        .NS_PER_SEC(32'd1_000_000_000),
        .EVT_DEPTH (4),
        .CNT_W     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .time_ptp_sec  (time_ptp_sec),
        .time_ptp_ns   (time_ptp_ns),
        .cfg_ld        (cfg_ld),
        .cfg_target_sec(cfg_target_sec),
        .cfg_target_ns (cfg_target_ns),
        .cfg_period_ns (cfg_period_ns),
        .cfg_width_ns  (cfg_width_ns),
        .cfg_count     (cfg_count),
        .arm           (arm),
        .disarm        (disarm),
        .trig_out      (trig_out),
        .trig_busy     (trig_busy),
        .trig_done     (trig_done),
        .trig_late     (trig_late),
        .cfg_err       (cfg_err),
        .evt_in        (evt_in),
        .evt_rd_en     (evt_rd_en),
        .evt_ts_out    (evt_ts_out),
        .evt_empty     (evt_empty),
        .evt_ovf       (evt_ovf),
        .evt_ovf_clr   (evt_ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_t(input logic [47:0] s, input logic [31:0] n);
        time_ptp_sec = s;
        time_ptp_ns  = n;
    endtask

    task automatic step(input logic [47:0] s, input logic [31:0] n,
                        input logic e, input string tag);
        set_t(s, n);
        tick();
        chk(tag, 80'(trig_out), 80'(e));
    endtask

    task automatic load(input logic [47:0] ts, input logic [31:0] tn,
                        input logic [31:0] per, input logic [31:0] wid,
                        input logic [15:0] cnt);
        cfg_target_sec = ts;
        cfg_target_ns  = tn;
        cfg_period_ns  = per;
        cfg_width_ns   = wid;
        cfg_count      = cnt;
        cfg_ld = 1'b1;
        tick();
        cfg_ld = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic edge_evt(input logic [47:0] s, input logic [31:0] n);
        set_t(s, n);
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
        tick();
    endtask

    task automatic pop();
        evt_rd_en = 1'b1;
        tick();
        evt_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        set_t(48'd0, 32'd0);
        cfg_ld = 0; cfg_target_sec = 0; cfg_target_ns = 0;
        cfg_period_ns = 0; cfg_width_ns = 0; cfg_count = 0;
        arm = 0; disarm = 0; evt_in = 0; evt_rd_en = 0; evt_ovf_clr = 0;
        tick();
        tick();
        chk("rst_out",   80'(trig_out),  80'd0);
        chk("rst_busy",  80'(trig_busy), 80'd0);
        chk("rst_done",  80'(trig_done), 80'd0);
        chk("rst_late",  80'(trig_late), 80'd0);
        chk("rst_err",   80'(cfg_err),   80'd0);
        chk("rst_empty", 80'(evt_empty), 80'd1);
        chk("rst_ovf",   80'(evt_ovf),   80'd0);
        chk("rst_ts",    evt_ts_out,     80'd0);
        rst = 1'b1;
        tick();

        // three pulses on the 1 s grid from 5 s
        load(48'd5, 32'd0, 32'd1_000_000_000, 32'd100_000_000, 16'd3);
        set_t(48'd4, 32'd999_999_990);
        do_arm();
        chk("a_busy", 80'(trig_busy), 80'd1);
        chk("a_late", 80'(trig_late), 80'd0);
        chk("a_out0", 80'(trig_out),  80'd0);
        step(48'd4, 32'd999_999_998, 1'b0, "a_pre5");
        step(48'd5, 32'd6,           1'b1, "a_rise5");
        step(48'd5, 32'd99_999_998,  1'b1, "a_hold5");
        step(48'd5, 32'd100_000_006, 1'b0, "a_fall5");
        chk("a_done5", 80'(trig_done), 80'd0);
        chk("a_busy5", 80'(trig_busy), 80'd1);
        step(48'd5, 32'd999_999_998, 1'b0, "a_pre6");
        step(48'd6, 32'd6,           1'b1, "a_rise6");
        step(48'd6, 32'd99_999_998,  1'b1, "a_hold6");
        step(48'd6, 32'd100_000_006, 1'b0, "a_fall6");
        chk("a_done6", 80'(trig_done), 80'd0);
        step(48'd6, 32'd999_999_998, 1'b0, "a_pre7");
        step(48'd7, 32'd6,           1'b1, "a_rise7");
        step(48'd7, 32'd99_999_998,  1'b1, "a_hold7");
        step(48'd7, 32'd100_000_006, 1'b0, "a_fall7");
        chk("a_done7", 80'(trig_done), 80'd1);
        chk("a_idle7", 80'(trig_busy), 80'd0);
        tick();
        chk("a_done_1cyc", 80'(trig_done), 80'd0);

        // pulse straddling a second boundary: fall at 11 s + 50 ns
        load(48'd10, 32'd999_999_950, 32'd1000, 32'd100, 16'd1);
        set_t(48'd10, 32'd999_999_900);
        do_arm();
        step(48'd10, 32'd999_999_949, 1'b0, "w_pre");
        step(48'd10, 32'd999_999_950, 1'b1, "w_rise");
        step(48'd10, 32'd999_999_999, 1'b1, "w_hold0");
        step(48'd11, 32'd49,          1'b1, "w_hold1");
        step(48'd11, 32'd50,          1'b0, "w_fall");
        chk("w_done", 80'(trig_done), 80'd1);

        // late arm: catch up through 19.0, 19.5, 20.0 then normal cadence
        load(48'd19, 32'd0, 32'd500_000_000, 32'd1000, 16'd0);
        set_t(48'd20, 32'd0);
        do_arm();
        chk("l_late", 80'(trig_late), 80'd1);
        step(48'd20, 32'd0, 1'b1, "l_r190");
        step(48'd20, 32'd0, 1'b0, "l_f190");
        step(48'd20, 32'd0, 1'b1, "l_r195");
        step(48'd20, 32'd0, 1'b0, "l_f195");
        step(48'd20, 32'd0, 1'b1, "l_r200");
        step(48'd20, 32'd0, 1'b1, "l_h200");
        step(48'd20, 32'd1000, 1'b0, "l_f200");
        step(48'd20, 32'd499_999_999, 1'b0, "l_pre205");
        step(48'd20, 32'd500_000_000, 1'b1, "l_r205");
        chk("l_busy", 80'(trig_busy), 80'd1);
        set_t(48'd20, 32'd500_000_008);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("l_dis_out",  80'(trig_out),  80'd0);
        chk("l_dis_busy", 80'(trig_busy), 80'd0);

        // width == period is illegal
        load(48'd30, 32'd0, 32'd1000, 32'd1000, 16'd2);
        set_t(48'd29, 32'd0);
        do_arm();
        chk("i_err",  80'(cfg_err),   80'd1);
        chk("i_busy", 80'(trig_busy), 80'd0);

        // disarm wins over arm
        load(48'd30, 32'd0, 32'd1000, 32'd500, 16'd1);
        arm = 1'b1;
        disarm = 1'b1;
        tick();
        arm = 1'b0;
        disarm = 1'b0;
        chk("d_busy", 80'(trig_busy), 80'd0);
        do_arm();
        chk("d_err_clr",  80'(cfg_err),   80'd0);
        chk("d_late_clr", 80'(trig_late), 80'd0);
        chk("d_busy2",    80'(trig_busy), 80'd1);
        step(48'd30, 32'd0, 1'b1, "d_rise");
        // a load while busy must not change count (still 1 -> done)
        load(48'd40, 32'd0, 32'd1000, 32'd100, 16'd0);
        chk("c_ign_out", 80'(trig_out), 80'd1);
        step(48'd30, 32'd500, 1'b0, "c_fall");
        chk("c_done", 80'(trig_done), 80'd1);

        // re-arm late; disarm in the same cycle the fall would fire
        do_arm();
        chk("d_late", 80'(trig_late), 80'd1);
        step(48'd30, 32'd500, 1'b1, "d_rise2");
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("d_out",   80'(trig_out),  80'd0);
        chk("d_nodone", 80'(trig_done), 80'd0);
        chk("d_idle",  80'(trig_busy), 80'd0);

        // event FIFO: five edges, one dropped
        edge_evt(48'd100, 32'd10);
        edge_evt(48'd100, 32'd20);
        edge_evt(48'd100, 32'd30);
        edge_evt(48'd100, 32'd40);
        chk("e_ovf4", 80'(evt_ovf), 80'd0);
        edge_evt(48'd100, 32'd50);
        chk("e_ovf5", 80'(evt_ovf),   80'd1);
        chk("e_head", evt_ts_out,     {48'd100, 32'd10});
        chk("e_nemp", 80'(evt_empty), 80'd0);
        set_t(48'd101, 32'd7);
        evt_in = 1'b1;
        evt_rd_en = 1'b1;
        tick();
        evt_in = 1'b0;
        evt_rd_en = 1'b0;
        chk("e_pw_head", evt_ts_out, {48'd100, 32'd20});
        pop();
        chk("e_h30", evt_ts_out, {48'd100, 32'd30});
        pop();
        chk("e_h40", evt_ts_out, {48'd100, 32'd40});
        pop();
        chk("e_h101", evt_ts_out, {48'd101, 32'd7});
        pop();
        chk("e_empty", 80'(evt_empty), 80'd1);
        pop();
        chk("e_empty_rd", 80'(evt_empty), 80'd1);
        edge_evt(48'd102, 32'd1);
        chk("e_h102", evt_ts_out, {48'd102, 32'd1});
        evt_ovf_clr = 1'b1;
        tick();
        evt_ovf_clr = 1'b0;
        chk("e_ovf_clr", 80'(evt_ovf), 80'd0);
        edge_evt(48'd102, 32'd2);
        edge_evt(48'd102, 32'd3);
        edge_evt(48'd102, 32'd4);
        set_t(48'd103, 32'd0);
        evt_in = 1'b1;
        evt_ovf_clr = 1'b1;
        tick();
        evt_in = 1'b0;
        evt_ovf_clr = 1'b0;
        chk("e_ovf_win", 80'(evt_ovf), 80'd1);
        chk("e_h_keep",  evt_ts_out,   {48'd102, 32'd1});

        // reset while a pulse is high and the FIFO holds data
        load(48'd200, 32'd0, 32'd1000, 32'd500, 16'd0);
        set_t(48'd199, 32'd0);
        do_arm();
        step(48'd200, 32'd0, 1'b1, "r_rise");
        rst = 1'b0;
        tick();
        chk("r_out",   80'(trig_out),  80'd0);
        chk("r_busy",  80'(trig_busy), 80'd0);
        chk("r_done",  80'(trig_done), 80'd0);
        chk("r_late",  80'(trig_late), 80'd0);
        chk("r_err",   80'(cfg_err),   80'd0);
        chk("r_empty", 80'(evt_empty), 80'd1);
        chk("r_ovf",   80'(evt_ovf),   80'd0);
        chk("r_ts",    evt_ts_out,     80'd0);
        rst = 1'b1;
        tick();
        // config cleared to zero: period 0 is illegal
        do_arm();
        chk("r_cfg0_err",  80'(cfg_err),   80'd1);
        chk("r_cfg0_busy", 80'(trig_busy), 80'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
